// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block: FSM state encoding,
// duty result width and serial divider iteration count.
package pwm_capture_pkg;

    // Width of the duty result (fraction of 256)
    localparam int DUTY_W      = 8;

    // One quotient bit per divider iteration
    localparam int DIV_STEPS   = DUTY_W;
    localparam int DIV_STEP_W  = $clog2(DIV_STEPS);

    // Input synchronizer depth: two stages for metastability, one for edge detect
    localparam int SYNC_STAGES = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MEAS  = 2'd1,
        S_STUCK = 2'd2
    } state_t;

    // Duty reported while the input is frozen: full-on or full-off
    function automatic logic [DUTY_W-1:0] stuck_duty(input logic level);
        return {DUTY_W{level}};
    endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// Serial restoring divider producing floor(dividend * 256 / divisor).
// One quotient bit per clock; the last quotient bit is folded into the
// combinational result so the caller can register it on the done cycle.
module pwm_duty_div
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = 20
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  dividend,
    input  logic [CNT_W-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quotient
);

    // One extra bit: the remainder is doubled before the compare
    logic [CNT_W:0]          rem_reg;
    logic [CNT_W-1:0]        div_reg;
    logic [DUTY_W-1:0]       quot_reg;
    logic [DIV_STEP_W-1:0]   step_reg;

    logic [CNT_W:0]          rem_shift;
    logic [CNT_W:0]          rem_next;
    logic                    quot_bit;
    logic [DUTY_W-1:0]       quot_next;
    logic                    last_step;

    // Single restoring step: double, trial-subtract, keep the difference if it fits
    always_comb begin
        rem_shift = rem_reg << 1;
        quot_bit  = (rem_shift >= {1'b0, div_reg});
        rem_next  = quot_bit ? (rem_shift - {1'b0, div_reg}) : rem_shift;
        quot_next = (quot_reg << 1) | DUTY_W'(quot_bit);
        last_step = (step_reg == DIV_STEP_W'(DIV_STEPS - 1));
    end

    // The final step's quotient is presented directly so the result is usable
    // in the same cycle as done
    assign done     = busy && last_step && !abort;
    assign quotient = quot_next;

    // Iteration control: load on start, shift each cycle, abort drops the job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            rem_reg  <= '0;
            div_reg  <= '0;
            quot_reg <= '0;
            step_reg <= '0;
        end else if (abort) begin
            busy     <= 1'b0;
            step_reg <= '0;
        end else if (start && !busy) begin
            busy     <= 1'b1;
            rem_reg  <= {1'b0, dividend};
            div_reg  <= divisor;
            quot_reg <= '0;
            step_reg <= '0;
        end else if (busy) begin
            rem_reg  <= rem_next;
            quot_reg <= quot_next;
            step_reg <= step_reg + 1'b1;
            if (last_step) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM input measurement: synchronizes PWM_IN, counts period and high time
// between rising edges, converts each accepted measurement to an 8-bit duty
// value with a serial divider and flags an input that has stopped toggling.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = 20
)
(
    input  logic              CLK50M,
    input  logic              RESET,
    input  logic              PWM_IN,
    output logic [CNT_W-1:0]  PERIOD,
    output logic [CNT_W-1:0]  HIGH_TIME,
    output logic [DUTY_W-1:0] DUTY,
    output logic              VALID,
    output logic              STUCK,
    output logic              DROP
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s2;
    logic                   s3;
    logic                   rise;
    logic                   fall;

    logic [CNT_W-1:0]       p_cnt;
    logic [CNT_W-1:0]       h_cnt;
    logic                   p_sat;
    logic                   h_sat;

    state_t                 state;
    logic                   accept;
    logic                   saturate;

    logic                   div_busy;
    logic                   div_done;
    logic [DUTY_W-1:0]      div_quot;

    // Three-flop synchronizer; the last stage only serves edge detection
    always_ff @(posedge CLK50M or posedge RESET) begin
        if (RESET) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], PWM_IN};
        end
    end

    assign s2   = sync_reg[1];
    assign s3   = sync_reg[2];
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    assign p_sat = &p_cnt;
    assign h_sat = &h_cnt;

    // A rise is only measured in MEAS; the divider must be free to take it
    assign accept   = rise && (state == S_MEAS) && !div_busy;
    // A rise in the saturating cycle restarts the counters, so it takes priority
    assign saturate = p_sat && !rise && (state != S_STUCK);
    // Rise arrived while the previous result is still being divided
    assign DROP     = rise && (state == S_MEAS) && div_busy;

    // Period and high-time counters, both restarted by each rise; the rise
    // cycle itself counts as the first cycle of the new period
    always_ff @(posedge CLK50M or posedge RESET) begin
        if (RESET) begin
            p_cnt <= '0;
            h_cnt <= '0;
        end else if (rise) begin
            p_cnt <= CNT_W'(1);
            h_cnt <= CNT_W'(1);
        end else begin
            if (!p_sat) begin
                p_cnt <= p_cnt + 1'b1;
            end
            if (s2 && !fall && !h_sat) begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (CLK50M),
        .rst      (RESET),
        .start    (accept),
        .abort    (saturate),
        .dividend (h_cnt),
        .divisor  (p_cnt),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // Measurement FSM and registered result outputs
    always_ff @(posedge CLK50M or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            PERIOD    <= '0;
            HIGH_TIME <= '0;
            DUTY      <= '0;
            VALID     <= 1'b0;
            STUCK     <= 1'b0;
        end else begin
            VALID <= 1'b0;

            // Divider result lands one cycle after its last iteration
            if (div_done) begin
                DUTY  <= div_quot;
                VALID <= 1'b1;
            end

            if (saturate) begin
                // No rise for a full counter range: report the frozen level
                state <= S_STUCK;
                STUCK <= 1'b1;
                DUTY  <= stuck_duty(s2);
                VALID <= 1'b1;
            end else if (rise) begin
                case (state)
                    S_IDLE: begin
                        // Partial period before the first rise is thrown away
                        state <= S_MEAS;
                    end
                    S_MEAS: begin
                        if (!div_busy) begin
                            PERIOD    <= p_cnt;
                            HIGH_TIME <= h_cnt;
                        end
                    end
                    S_STUCK: begin
                        // Toggling resumed; the next full period is measured
                        state <= S_MEAS;
                        STUCK <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture (CNT_W = 8 so saturation is reachable quickly).
// The reference model works on the recorded input waveform: it finds rising
// edges of the synchronized input, derives period/high time by counting
// cycles, and schedules the expected VALID/DROP/STUCK events.
module tb_pwm_capture;

    localparam int W = 8;
    localparam int SAT = (1 << W) - 1;
    localparam int M_IDLE = 0, M_MEAS = 1, M_STUCK = 2;

    logic         clk = 1'b0;
    logic         RESET = 1'b0;
    logic         PWM_IN = 1'b0;
    logic [W-1:0] PERIOD;
    logic [W-1:0] HIGH_TIME;
    logic [7:0]   DUTY;
    logic         VALID;
    logic         STUCK;
    logic         DROP;

    pwm_capture #(.CNT_W(W)) dut (
        .CLK50M    (clk),
        .RESET     (RESET),
        .PWM_IN    (PWM_IN),
        .PERIOD    (PERIOD),
        .HIGH_TIME (HIGH_TIME),
        .DUTY      (DUTY),
        .VALID     (VALID),
        .STUCK     (STUCK),
        .DROP      (DROP)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct { int cyc; int duty; } vld_t;
    vld_t q[$];
    bit   hist[$];
    int   c;
    int   mode;
    int   last_rise;
    int   div_end;
    int   exp_period, exp_high, exp_duty, exp_stuck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, c, obs, exp);
        end
    endtask

    // Synchronized input level in cycle k: the value driven two cycles earlier
    function automatic bit sync_at(int k);
        if (k - 2 >= 0 && k - 2 < hist.size()) return hist[k-2];
        return 1'b0;
    endfunction

    task automatic model_init();
        q.delete();
        hist.delete();
        c = 0;
        mode = M_IDLE;
        last_rise = -1;
        div_end = -100;
        exp_period = 0; exp_high = 0; exp_duty = 0; exp_stuck = 0;
    endtask

    // Check outputs for the current cycle, advance the model, drive next input
    task automatic tick(input bit v);
        bit   rise, exp_v, exp_d;
        int   period, high;
        vld_t e;
        rise  = sync_at(c) && !sync_at(c - 1);
        exp_d = rise && (mode == M_MEAS) && (c <= div_end);
        exp_v = (q.size() > 0) && (q[0].cyc == c);
        if (exp_v) begin
            e = q.pop_front();
            exp_duty = e.duty;
        end
        chk("valid",  32'(VALID),     32'(exp_v));
        chk("drop",   32'(DROP),      32'(exp_d));
        chk("stuck",  32'(STUCK),     32'(exp_stuck));
        chk("duty",   32'(DUTY),      32'(exp_duty));
        chk("period", 32'(PERIOD),    32'(exp_period));
        chk("high",   32'(HIGH_TIME), 32'(exp_high));
        if (exp_v)
            $display("valid cycle=%0d period=%0d high=%0d duty=%0d stuck=%0d", c, PERIOD, HIGH_TIME, DUTY, STUCK);
        if (rise) begin
            if (mode == M_MEAS && c > div_end) begin
                period = c - last_rise;
                high = 0;
                for (int k = last_rise; k < c; k++) high += int'(sync_at(k));
                exp_period = period;
                exp_high   = high;
                q.push_back('{cyc: c + 9, duty: (high * 256) / period});
                div_end = c + 8;
            end else if (mode == M_STUCK) begin
                exp_stuck = 0;
            end
            mode = M_MEAS;
            last_rise = c;
        end else if (mode != M_STUCK && c - last_rise == SAT) begin
            mode = M_STUCK;
            exp_stuck = 1;
            q.delete();
            q.push_back('{cyc: c + 1, duty: sync_at(c) ? 255 : 0});
            div_end = -100;
        end
        PWM_IN = v;
        hist.push_back(v);
        @(negedge clk);
        c++;
    endtask

    task automatic pwm_period(input int p, input int h);
        for (int i = 0; i < p; i++) tick(i < h);
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    // Caller places this away from a clock edge; outputs must clear at once
    task automatic do_reset();
        RESET = 1'b1;
        #1;
        chk("rst_period", 32'(PERIOD),    32'd0);
        chk("rst_high",   32'(HIGH_TIME), 32'd0);
        chk("rst_duty",   32'(DUTY),      32'd0);
        chk("rst_valid",  32'(VALID),     32'd0);
        chk("rst_stuck",  32'(STUCK),     32'd0);
        chk("rst_drop",   32'(DROP),      32'd0);
        $display("reset applied at %0t", $time);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        RESET  = 1'b0;
        PWM_IN = 1'b0;
        model_init();
        @(negedge clk);
    endtask

    initial begin
        int p, h;
        #2;
        do_reset();

        // 100/25: first period discarded, then DUTY = 64
        for (int i = 0; i < 3; i++) pwm_period(100, 25);
        // 100/99 -> 253, then 10/1 -> 25
        for (int i = 0; i < 2; i++) pwm_period(100, 99);
        for (int i = 0; i < 3; i++) pwm_period(10, 1);
        // Period 4: rises inside the divide window are dropped
        for (int i = 0; i < 8; i++) pwm_period(4, 2);

        // Stuck high -> DUTY FF, recovery with 20/5 -> 64
        for (int i = 0; i < 2; i++) pwm_period(20, 5);
        hold(1'b1, 300);
        for (int i = 0; i < 4; i++) pwm_period(20, 5);

        // Stuck low -> DUTY 00, recovery
        hold(1'b0, 300);
        for (int i = 0; i < 3; i++) pwm_period(20, 5);

        // Random periods, including ones short enough to be dropped
        for (int i = 0; i < 30; i++) begin
            p = int'($urandom_range(60, 2));
            h = int'($urandom_range(p - 1, 1));
            pwm_period(p, h);
        end
        pwm_period(20, 5);

        // Asynchronous reset while a divide is in flight
        for (int i = 0; i < 3; i++) pwm_period(20, 5);
        hold(1'b1, 4);
        #5;
        do_reset();
        for (int i = 0; i < 4; i++) pwm_period(20, 5);
        hold(1'b0, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an externally driven PWM signal, such as an LED dimming line or fan tach-style duty input, on the 50 MHz board clock. It reports period, high time and an 8-bit duty value (high·256/period) each time a full cycle completes. It also flags a stuck (non-toggling) input. It is the receive-side counterpart of the board's LED PWM generators and is used for loopback checks and for reading external duty-coded controls.

## Interface
- CNT_W, default 20: width of period/high counters; max measurable period 2^CNT_W−1 cycles.
- CLK50M  in  1  system clock, 50 MHz.
- RESET  in  1  reset; one clock, reset is asynchronous and active-high.
- PWM_IN  in  1  asynchronous PWM input.
- PERIOD  out  CNT_W  cycles from rising edge to rising edge of the last accepted measurement.
- HIGH_TIME  out  CNT_W  high cycles of the last accepted measurement.
- DUTY  out  8  floor(HIGH_TIME·256/PERIOD); 8'hFF/8'h00 when stuck.
- VALID  out  1  one-cycle pulse when DUTY/PERIOD/HIGH_TIME updated.
- STUCK  out  1  level; input has not risen for 2^CNT_W−1 cycles.
- DROP  out  1  one-cycle pulse when a completed period was discarded because the divider was busy.

## Operation
- Input sync: PWM_IN → s1 → s2 → s3, all reset to 0. Rise = s2 & ~s3. Fall = ~s2 & s3.
- FSM states:
  - IDLE: after reset. Waits for the first rise. That rise goes to MEAS; the partial period before it is discarded.
  - MEAS: counting.
  - STUCK: counter saturated.
- Counters p_cnt and h_cnt:
  - On a rise, both load 1.
  - Otherwise p_cnt increments each cycle, saturating at all-ones.
  - h_cnt increments while s2=1 and no fall is occurring; it freezes after the fall.
- Rise in MEAS:
  - If the divider is idle, latch PERIOD←p_cnt and HIGH_TIME←h_cnt, then start the divider.
  - If the divider is busy, pulse DROP and leave the outputs unchanged.
  - In both cases the counters restart.
- Saturation: p_cnt reaching all-ones in MEAS or IDLE moves the FSM to STUCK. In the same cycle:
  - STUCK←1, DUTY←s2 ? 8'hFF : 8'h00.
  - PERIOD and HIGH_TIME are unchanged, and VALID is pulsed.
  - Any divider operation in flight is aborted, with no VALID from it.
- Rise in STUCK: STUCK←0 and the FSM goes to MEAS. That first period is measured normally.
- Divider: restoring divider, 8 iterations, remainder width CNT_W+1.
  - rem←HIGH_TIME.
  - Each step: rem←2·rem; if rem ≥ PERIOD then rem −= PERIOD and the quotient bit is 1.
  - HIGH_TIME < PERIOD always holds, so the quotient fits in 8 bits.
- Reset values: all outputs 0, FSM IDLE, divider idle. Reset mid-measurement or mid-divide abandons all work immediately, with no VALID.

## Timing
- A PWM_IN change captured at clock edge e appears as rise/fall in the cycle after edge e+1 (2-cycle sync latency).
- A rise accepted in cycle N:
  - PERIOD and HIGH_TIME update at the edge ending cycle N.
  - The divider runs cycles N+1..N+8.
  - DUTY updates and VALID is high in cycle N+9 (9 cycles after the rise).
- The minimum accepted period rate is one per 9 cycles. A rise during divider cycles N+1..N+8 gives a DROP pulse in the same cycle.
- A rise in the same cycle as saturation: the rise wins (saturation is ignored), so STUCK is never set.
- STUCK and DUTY take the saturation value at the edge ending the cycle in which p_cnt = 2^CNT_W−1. VALID is high in the following cycle.

## Structure
- Package pwm_capture_pkg: state enum (IDLE, MEAS, STUCK), DUTY_W=8, divider iteration count constant.
- Sub-module pwm_duty_div (start/busy/done handshake, abort input, CNT_W parameter) holds the serial divider.
- Top level holds the synchronizer, counters, FSM and output registers.

## Test plan
- Reset, then 3 periods of 100 cycles with 25 high → first period discarded. Two VALID pulses with PERIOD=100, HIGH_TIME=25, DUTY=64. Each VALID lands 9 cycles after its synced rise.
- Period 100, high 99 → DUTY=253; period 10, high 1 → DUTY=25.
- Period 4 (high 2) → DUTY=128 on the accepted period; DROP pulses for the following rises inside the 8-cycle divide window. No VALID for dropped periods.
- CNT_W=8, hold PWM_IN high after a valid period → STUCK=1 and DUTY=8'hFF exactly 255 cycles after the last rise, with a VALID pulse. Then toggle with period 20, high 5 → STUCK=0 and the next VALID gives DUTY=64.
- Same as the previous scenario with PWM_IN held low → DUTY=8'h00.
- Assert RESET asynchronously mid-divide → all outputs 0 immediately. No VALID afterwards until the first full period after reset is measured.
